// File: rtl/i2c_target_avalon.sv
// rtl/i2c_target_avalon.sv - I2C target with a four-byte register bank shared with Avalon-MM.
// The I2C side uses a pointer with auto-increment; the CPU gets an irq when a controller write ends.
module i2c_target_avalon #(
  parameter logic [6:0] TARGET_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        scl,
  inout  wire         sda
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t      state_q;
  logic [2:0]  scl_sync_q, sda_sync_q;
  logic [6:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  tx_q;
  logic [1:0]  ptr_q;
  logic [7:0]  regs_q [4];
  logic        rw_q, ack_on_q, sda_oe_q;
  logic        txn_wrote_q, wr_done_q, irq_en_q;

  logic        scl_rise_d, scl_fall_d, start_d, stop_d, sda_in_d;
  logic [7:0]  rx_byte_d;
  logic        unused_wdata;

  // [0] and [1] are the synchroniser, [2] is the delay stage used for edges
  assign sda_in_d   = sda_sync_q[1];
  assign scl_rise_d = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall_d = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_d    = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_d     = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
  assign rx_byte_d  = {shift_q, sda_in_d};

  assign sda          = sda_oe_q ? 1'b0 : 1'bz;
  assign irq          = irq_en_q & wr_done_q;
  assign unused_wdata = ^writedata[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      scl_sync_q  <= 3'b111;
      sda_sync_q  <= 3'b111;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      rw_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      txn_wrote_q <= 1'b0;
      wr_done_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      readdata    <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl};
      sda_sync_q <= {sda_sync_q[1:0], sda};

      // CPU writes come first so an I2C commit or STOP below overrides them
      if (chipselect && write) begin
        if (!address[2]) begin
          regs_q[address[1:0]] <= writedata[7:0];
        end else if (address[1:0] == 2'd0) begin
          irq_en_q <= writedata[0];
          if (writedata[1]) wr_done_q <= 1'b0;
        end
      end

      if (start_d) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        ack_on_q  <= 1'b0;
        sda_oe_q  <= 1'b0;
      end else if (stop_d) begin
        state_q     <= IDLE;
        ack_on_q    <= 1'b0;
        sda_oe_q    <= 1'b0;
        txn_wrote_q <= 1'b0;
        if (txn_wrote_q) wr_done_q <= 1'b1;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise_d) begin
              shift_q   <= rx_byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (rx_byte_d[7:1] == TARGET_ADDR) begin
                  rw_q    <= rx_byte_d[0];
                  state_q <= ADDR_ACK;
                end else begin
                  state_q <= IDLE;
                end
              end
            end
          end
          PTR, WDATA: begin
            if (scl_rise_d) begin
              shift_q   <= rx_byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == PTR) begin
                  ptr_q   <= rx_byte_d[1:0];
                  state_q <= PTR_ACK;
                end else begin
                  regs_q[ptr_q] <= rx_byte_d;
                  ptr_q         <= ptr_q + 2'd1;
                  txn_wrote_q   <= 1'b1;
                  state_q       <= WDATA_ACK;
                end
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            // first fall ends the eighth bit and starts the ACK, second fall ends it
            if (scl_fall_d) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                ack_on_q  <= 1'b0;
                bit_cnt_q <= '0;
                if (state_q == ADDR_ACK && rw_q) begin
                  state_q  <= RDATA;
                  tx_q     <= regs_q[ptr_q];
                  sda_oe_q <= ~regs_q[ptr_q][7];
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == ADDR_ACK) ? PTR : WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise_d) bit_cnt_q <= bit_cnt_q + 3'd1;
            if (scl_fall_d) begin
              if (bit_cnt_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                ptr_q    <= ptr_q + 2'd1;
                ack_on_q <= 1'b0;
                state_q  <= RACK;
              end else begin
                sda_oe_q <= ~tx_q[3'd7 - bit_cnt_q];
              end
            end
          end
          RACK: begin
            if (scl_rise_d) begin
              if (sda_in_d) state_q <= IDLE;
              else          ack_on_q <= 1'b1;
            end
            if (scl_fall_d && ack_on_q) begin
              ack_on_q  <= 1'b0;
              bit_cnt_q <= '0;
              tx_q      <= regs_q[ptr_q];
              sda_oe_q  <= ~regs_q[ptr_q][7];
              state_q   <= RDATA;
            end
          end
          default: ;
        endcase
      end

      if (!address[2])
        readdata <= {24'b0, regs_q[address[1:0]]};
      else if (address[1:0] == 2'd0)
        readdata <= {26'b0, (state_q != IDLE), wr_done_q, irq_en_q, 1'b0, ptr_q};
      else
        readdata <= '0;
    end
  end

endmodule

// File: doc/i2c_target_avalon.md
# i2c_target_avalon

I2C target (slave) responder with a four-byte register bank shared between an external I2C controller and the Nios II over Avalon-MM. It is the far end of the I2C controller link: a controller addresses it, sets a register pointer, then writes or reads bytes with pointer auto-increment. The CPU reads and writes the same bytes through Avalon and is interrupted when a controller write transaction completes.

## Interface
- TARGET_ADDR, 7'h48, 7-bit I2C address this block ACKs
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- chipselect  in  1  Avalon select
- write  in  1  Avalon write strobe
- address  in  3  0–3 = register bytes, 4 = status/control
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- irq  out  1  interrupt, = irq_en & wr_done
- scl  in  1  I2C clock (target never stretches)
- sda  inout  1  I2C data, open-drain: driven 0 or released to Z

## Operation
- scl/sda pass through 2-FF synchronisers plus one delay stage; all edges detected on synchronised signals.
- START: sda falls while scl high. STOP: sda rises while scl high. Both recognised in every state, including mid-byte.
- Bits sampled on scl rising edge, MSB first; sda output changes only after scl falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
- IDLE: wait for START -> ADDR.
- ADDR: shift 8 bits. If bits[7:1] = TARGET_ADDR -> ADDR_ACK; else -> IDLE, ignoring all traffic until next START.
- ADDR_ACK: drive sda=0 for the ninth clock. R/W=0 -> PTR; R/W=1 -> RDATA with reg[ptr] preloaded.
- PTR: shift 8 bits; ptr <= byte[1:0]; upper bits ignored -> PTR_ACK (ACK) -> WDATA.
- WDATA: shift 8 bits; at the eighth rising edge reg[ptr] <= byte, ptr <= ptr+1 mod 4, set txn_wrote -> WDATA_ACK (ACK) -> WDATA.
- RDATA: drive reg[ptr] MSB first (0 = drive low, 1 = release); after the eighth bit release sda, ptr <= ptr+1 -> RACK.
- RACK: sample controller ACK on the ninth rising edge. ACK (0) -> RDATA, next byte loaded; NACK (1) -> IDLE, sda released.
- Repeated START in any state -> ADDR; ptr is kept, so write-pointer-then-read works.
- STOP in any state -> IDLE, sda released; if txn_wrote, set wr_done; clear txn_wrote.
- Avalon addr 0–3 write: reg[address] <= writedata[7:0]. Read: {24'b0, reg}.
- Avalon addr 4 read: {26'b0, busy, wr_done, irq_en, 1'b0, ptr[1:0]}. busy = FSM not IDLE.
- Avalon addr 4 write: irq_en <= writedata[0]; writedata[1]=1 clears wr_done (W1C).
- Avalon addr 5–7: writes ignored, reads return 0.

## Timing
- Reset values: regs 0, ptr 0, irq_en 0, wr_done 0, FSM IDLE, sda released (Z), irq 0, readdata 0.
- reset_n low releases sda asynchronously, even mid-transaction.
- readdata is registered on every clk from the current address: 1-cycle read latency, no waitrequest.
- Input-to-detection latency: 3 clk. scl high and low phases must each be at least 5 clk; sda hold after scl fall must be at least 4 clk.
- ACK or data drive begins 3–4 clk after the actual scl fall and holds until the next scl fall is detected.
- Same-cycle Avalon write and I2C commit to the same byte: I2C value wins.
- Same-cycle STOP-set and W1C of wr_done: set wins.
- irq is combinational from registered irq_en and wr_done; no glitch path from the bus.

## Test plan
- Reset: hold reset_n low mid-read with sda driven low -> sda goes Z immediately; status reads 0; regs read 0.
- Write burst: START, 0x90, ptr 0x03, 0xAA, 0xBB, STOP -> all four bytes ACKed; reg3=0xAA, reg0=0xBB (wrap); wr_done=1; irq=1 once irq_en=1; W1C drops irq.
- Pointer then read: Avalon writes reg1=0x5A and reg2=0xC3; I2C START, 0x90, ptr 0x01, repeated START, 0x91, read two bytes (ACK, then NACK), STOP -> controller receives 0x5A, 0xC3; wr_done stays 0.
- Address mismatch: START, 0x92, byte, STOP -> no ACK, regs unchanged, busy=0 after the mismatch.
- Collision: Avalon write reg0=0x11 on the same cycle as an I2C commit of 0x22 to reg0 -> reg0=0x22.
- STOP mid-byte: START, 0x90, ptr 0, 4 bits, then STOP -> FSM returns to IDLE, reg0 unchanged, wr_done=0, sda released.
